spi_master: RTL and testbench

Single-clock SPI master that drives the team's 10-bit SPI slave protocol from a parallel request interface. It serialises a 10-bit frame (2-bit opcode plus 8-bit payload) MSB first on MOSI under an active-low SS_n. For read-data frames (opcode 2'b11) it also captures an 8-bit response from MISO. It sits between the system-side controller/testbench driver and the SPI slave/RAM wrapper, all in the `clk` domain (no separate SCK; slave samples on `clk`).

---
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master for the 10-bit slave protocol: 2-bit opcode + 8-bit payload, MSB first.
// Everything runs on clk, and the slave samples on the same clock.
// Read-data frames (opcode 2'b11) are followed by a turnaround and an 8-bit MISO capture.
module spi_master #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] tx_word,
  input  logic       MISO,
  output logic       SS_n,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  typedef enum logic [2:0] {
    StIdle, StSel, StCmd, StShift, StTurn, StRecv, StHold, StGap
  } state_t;

  localparam logic [3:0] TurnLast = 4'(TURNAROUND - 1);
  localparam logic [3:0] GapLast  = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [9:0] word;
  logic [6:0] rx;

  // Frame sequencer; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= 4'd0;
      word     <= 10'd0;
      rx       <= 7'd0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (start) begin
            word  <= tx_word;
            busy  <= 1'b1;
            SS_n  <= 1'b0;
            state <= StSel;
          end
        end
        StSel: begin
          // CMD cycle repeats the read/write select bit for the slave's command check.
          MOSI  <= word[9];
          state <= StCmd;
        end
        StCmd: begin
          MOSI  <= word[9];
          cnt   <= 4'd9;
          state <= StShift;
        end
        StShift: begin
          // cnt holds the index of the bit currently on MOSI.
          if (cnt != 4'd0) begin
            cnt  <= cnt - 4'd1;
            MOSI <= word[cnt - 4'd1];
          end else begin
            MOSI <= 1'b0;
            if (word[9:8] == 2'b11) begin
              cnt   <= TurnLast;
              state <= StTurn;
            end else begin
              state <= StHold;
            end
          end
        end
        StTurn: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            cnt   <= 4'd7;
            state <= StRecv;
          end
        end
        StRecv: begin
          rx <= {rx[5:0], MISO};
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rd_data  <= {rx, MISO};
            rd_valid <= 1'b1;
            done     <= 1'b1;
            SS_n     <= 1'b1;
            cnt      <= GapLast;
            state    <= StGap;
          end
        end
        StHold: begin
          done  <= 1'b1;
          SS_n  <= 1'b1;
          cnt   <= GapLast;
          state <= StGap;
        end
        StGap: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (start) begin
            // Back-to-back: accept on the edge leaving GAP so the gap is exactly GAP_CYCLES.
            word  <= tx_word;
            SS_n  <= 1'b0;
            state <= StSel;
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM model and a frame scoreboard.
module tb_spi_master;

  localparam int unsigned TA  = 3;
  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] tx_word = 10'd0;
  logic       MISO = 1'b0;
  logic       SS_n, MOSI, busy, done, rd_valid;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  spi_master #(.TURNAROUND(TA), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_word  (tx_word),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [9:0] w;
    int         len;
    logic       rv;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];

  // Slave model and frame monitor state
  logic [7:0]  mem [256];
  logic [7:0]  sl_addr = 8'h00;
  logic [7:0]  sl_raddr = 8'h00;
  logic [7:0]  tmp;
  logic [11:0] cap = 12'd0;
  exp_t        e;
  int          k = 0;
  int          hi_run = 0;
  int          last_gap = 0;
  int          frames = 0;
  int          dones = 0;
  logic        prev_done = 1'b0;

  // Monitor and slave: sample DUT on the falling edge, drive MISO for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      k = 0;
      hi_run = 0;
      prev_done = 1'b0;
      MISO = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", done, 0);
      check("rv_only_with_done", rd_valid & ~done, 0);
      prev_done = done;
      if (!SS_n) begin
        if (k == 0) begin
          last_gap = hi_run;
          frames++;
        end
        hi_run = 0;
        if (k < 12) cap[11-k] = MOSI;
        if (k == 12) begin
          case (cap[9:8])
            2'b00: sl_addr = cap[7:0];
            2'b01: mem[sl_addr] = cap[7:0];
            2'b10: sl_raddr = cap[7:0];
            default: ;
          endcase
        end
        if (cap[9:8] == 2'b11 && k >= 12 + TA && k < 20 + TA) begin
          tmp = mem[sl_raddr];
          MISO = tmp[19+TA-k];
        end else begin
          MISO = 1'b0;
        end
        k++;
      end else begin
        hi_run++;
        MISO = 1'b0;
        if (done) begin
          dones++;
          check("done_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("mosi_bits", cap, {1'b0, e.w[9], e.w});
            check("ss_low_len", k, e.len);
            check("rd_valid", rd_valid, e.rv);
            check("rd_data", rd_data, e.rd);
          end
        end
        k = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] w, input logic [7:0] rd);
    exp_t x;
    x.w   = w;
    x.rv  = (w[9:8] == 2'b11);
    x.len = x.rv ? 20 + TA : 13;
    x.rd  = rd;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input bit scramble);
    int n = 0;
    while (busy && n < 100) begin
      if (scramble) tx_word = 10'($urandom);
      tick;
      n++;
    end
    check("idle_in_time", busy, 0);
  endtask

  task automatic send(input logic [9:0] w, input bit scramble);
    tx_word = w;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("ss_low_after_accept", SS_n, 0);
    check("busy_after_accept", busy, 1);
    wait_idle(scramble);
  endtask

  logic [7:0] exp_rd;
  int f0, d0, n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hC3;
    exp_rd = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", SS_n, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    tick;

    // Write-address frame
    push(10'b00_1010_0101, exp_rd);
    send(10'b00_1010_0101, 1'b0);

    // Read-data frame, slave returns C3
    push(10'b11_0000_0000, 8'hC3);
    send(10'b11_0000_0000, 1'b0);
    exp_rd = 8'hC3;
    check("rd_data_held", rd_data, 8'hC3);

    // tx_word churns after acceptance
    push(10'b01_0011_1100, exp_rd);
    send(10'b01_0011_1100, 1'b1);

    // Back-to-back with start held high
    f0 = frames;
    push(10'b10_0000_0001, exp_rd);
    push(10'b00_1111_0000, exp_rd);
    tx_word = 10'b10_0000_0001;
    start = 1'b1;
    tick;
    tx_word = 10'b00_1111_0000;
    n = 0;
    while (frames < f0 + 2 && n < 100) begin
      tick;
      n++;
    end
    check("b2b_second_frame", frames, f0 + 2);
    check("b2b_gap", last_gap, GAP);
    start = 1'b0;
    wait_idle(1'b0);
    repeat (5) tick;
    check("b2b_no_third", frames, f0 + 2);

    // start pulses while busy are ignored
    f0 = frames;
    push(10'b01_0101_0101, exp_rd);
    tx_word = 10'b01_0101_0101;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_idle(1'b0);
    repeat (4) tick;
    check("no_extra_frames", frames, f0 + 1);

    // End-to-end through the slave RAM
    push(10'b00_0001_0000, exp_rd);
    send(10'b00_0001_0000, 1'b0);
    push(10'b01_0101_1010, exp_rd);
    send(10'b01_0101_1010, 1'b0);
    push(10'b10_0001_0000, exp_rd);
    send(10'b10_0001_0000, 1'b0);
    push(10'b11_0000_0000, 8'h5A);
    send(10'b11_0000_0000, 1'b0);
    exp_rd = 8'h5A;
    check("e2e_rd_data", rd_data, 8'h5A);

    // Reset in the middle of SHIFT aborts the frame
    d0 = dones;
    tx_word = 10'b00_1111_0000;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    check("mid_frame_busy", busy, 1);
    check("mid_frame_ss_low", SS_n, 0);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ss_n", SS_n, 1);
    check("async_rst_mosi", MOSI, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_data", rd_data, 8'h00);
    check("async_rst_done", done, 0);
    tick;
    rst = 1'b0;
    repeat (30) tick;
    check("no_done_after_reset", dones, d0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
